// File: rtl/div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : div_pkg                                                       |
// | Description : Shared definitions for the iterative restoring divider:      |
// |               default operand width, derived dividend width, state codes. |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
package div_pkg;

  // Divisor / remainder width; the dividend and quotient are twice as wide.
  localparam int DIV_SIZE = 4;
  localparam int DIV_N    = 2 * DIV_SIZE;

  // State encoding shared by every divider variant.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_CALC = CALC,
    ST_DONE = DONE
  } state_e;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : div_step                                                      |
// | Description : One combinational restoring-division stage. Shifts the next |
// |               dividend bit into the partial remainder and subtracts the   |
// |               divisor when it fits, producing one quotient bit.           |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module div_step
  import div_pkg::*;
#(
  parameter int SIZE = DIV_SIZE
) (
  input  logic [SIZE-1:0] partial_i,
  input  logic            bit_i,
  input  logic [SIZE-1:0] divisor_i,
  output logic [SIZE-1:0] partial_o,
  output logic            qbit_o
);

  logic [SIZE:0] w_shifted;
  logic [SIZE:0] w_diff;
  logic          w_fits;

  // Compare and subtract at SIZE+1 bits; when the divisor does not fit the
  // shifted value is below the divisor, so its top bit is always zero.
  always_comb begin
    w_shifted = {partial_i, bit_i};
    w_fits    = (w_shifted >= {1'b0, divisor_i});
    w_diff    = w_shifted - {1'b0, divisor_i};
    qbit_o    = w_fits;
    partial_o = w_fits ? w_diff[SIZE-1:0] : w_shifted[SIZE-1:0];
  end

endmodule : div_step
`default_nettype wire

// File: rtl/div_iter_8by4.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : div_iter_8by4                                                 |
// | Description : Iterative unsigned restoring divider, 2*SIZE-bit dividend by |
// |               SIZE-bit divisor, one quotient bit per cycle, valid/ready   |
// |               handshakes on both sides, registered results.               |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module div_iter_8by4
  import div_pkg::*;
#(
  parameter  int SIZE = DIV_SIZE,
  localparam int N    = 2 * SIZE,
  localparam int CW   = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N-1:0]    dividend,
  input  logic [SIZE-1:0] divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N-1:0]    quotient,
  output logic [SIZE-1:0] remainder,
  output logic            div_zero
);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    dvd_q, dvd_d;
  logic [SIZE-1:0] dvs_q, dvs_d;
  logic [SIZE-1:0] part_q, part_d;
  logic [N-1:0]    qwork_q, qwork_d;
  logic [N-1:0]    quot_q, quot_d;
  logic [SIZE-1:0] rem_q, rem_d;
  logic            dz_q, dz_d;

  logic [SIZE-1:0] w_step_part;
  logic            w_step_qbit;

  div_step #(.SIZE(SIZE)) u_step (
    .partial_i (part_q),
    .bit_i     (dvd_q[cnt_q]),
    .divisor_i (dvs_q),
    .partial_o (w_step_part),
    .qbit_o    (w_step_qbit)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      part_q  <= '0;
      qwork_q <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      part_q  <= part_d;
      qwork_q <= qwork_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  // Next-state, datapath update and handshake outputs (state-only decode).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    part_d    = part_q;
    qwork_d   = qwork_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    dz_d      = dz_q;
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_DONE);

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          dvd_d   = dividend;
          dvs_d   = divisor;
          part_d  = '0;
          qwork_d = '0;
          if (divisor == '0) begin
            // Zero divisor skips the iteration and reports a saturated quotient.
            state_d = ST_DONE;
            cnt_d   = '0;
            quot_d  = '1;
            rem_d   = '0;
            dz_d    = 1'b1;
          end else begin
            state_d = ST_CALC;
            cnt_d   = CW'(N - 1);
          end
        end
      end
      ST_CALC: begin
        part_d         = w_step_part;
        qwork_d[cnt_q] = w_step_qbit;
        if (cnt_q == '0) begin
          // Last bit: publish the full quotient and final remainder together.
          state_d = ST_DONE;
          quot_d  = qwork_d;
          rem_d   = w_step_part;
          dz_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign div_zero  = dz_q;

endmodule : div_iter_8by4
`default_nettype wire
